// File: rtl/edge_event_arbiter.sv
// Edge-event collector: per-channel edge detect into a pending slot, then
// round-robin serialisation of pending events onto a registered valid/ready port.

module edge_event_lane #(
  parameter logic INITIAL_DATA = 1'b0,
  parameter logic DETECT_RISE  = 1'b1,
  parameter logic DETECT_FALL  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  input  logic grant_i,
  input  logic clr_ovf_i,
  output logic pend_o,
  output logic ptype_o,
  output logic ovf_o
);
  logic lvl_q, pend_q, pend_d, ptype_q, ptype_d, ovf_q, ovf_d;
  logic rise, fall, edg;

  assign rise = level_i & ~lvl_q & DETECT_RISE;
  assign fall = ~level_i & lvl_q & DETECT_FALL;
  assign edg  = rise | fall;

  always_comb begin
    pend_d  = pend_q;
    ptype_d = ptype_q;
    ovf_d   = clr_ovf_i ? 1'b0 : ovf_q;
    if (grant_i) begin
      // old event leaves for the output slot; a same-cycle edge refills it
      pend_d = edg;
      if (edg) ptype_d = fall;
    end else if (edg) begin
      if (!pend_q) begin
        pend_d  = 1'b1;
        ptype_d = fall;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q   <= INITIAL_DATA;
      pend_q  <= 1'b0;
      ptype_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      lvl_q   <= level_i;
      pend_q  <= pend_d;
      ptype_q <= ptype_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pend_o  = pend_q;
  assign ptype_o = ptype_q;
  assign ovf_o   = ovf_q;
endmodule

module edge_event_arbiter #(
  parameter int   N            = 4,
  parameter logic INITIAL_DATA = 1'b0,
  parameter logic DETECT_RISE  = 1'b1,
  parameter logic DETECT_FALL  = 1'b0,
  parameter int   IDW          = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   level,
  output logic           event_valid,
  input  logic           event_ready,
  output logic [IDW-1:0] event_id,
  output logic           event_fall,
  output logic [N-1:0]   overflow,
  input  logic           clear_overflow
);
  logic [N-1:0]   pend, ptype, gnt_vec;
  logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, win_idx;
  logic           valid_q, valid_d, fall_q, fall_d;
  logic           slot_free, win_found, grant;

  for (genvar g = 0; g < N; g++) begin : g_lane
    edge_event_lane #(
      .INITIAL_DATA(INITIAL_DATA),
      .DETECT_RISE (DETECT_RISE),
      .DETECT_FALL (DETECT_FALL)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .level_i  (level[g]),
      .grant_i  (gnt_vec[g]),
      .clr_ovf_i(clear_overflow),
      .pend_o   (pend[g]),
      .ptype_o  (ptype[g]),
      .ovf_o    (overflow[g])
    );
  end

  assign slot_free = ~valid_q | event_ready;

  // Round-robin search starting at ptr, wrapping at N (not at 2**IDW).
  always_comb begin
    int p;
    p         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N; k++) begin
      p = int'(ptr_q) + k;
      if (p >= N) p = p - N;
      if (!win_found && pend[p]) begin
        win_found = 1'b1;
        win_idx   = IDW'(p);
      end
    end
  end

  assign grant = slot_free & win_found;

  always_comb begin
    gnt_vec = '0;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    id_d    = id_q;
    fall_d  = fall_q;
    if (slot_free) valid_d = win_found;
    if (grant) begin
      gnt_vec[win_idx] = 1'b1;
      id_d   = win_idx;
      fall_d = ptype[win_idx];
      ptr_d  = (win_idx == IDW'(N-1)) ? '0 : win_idx + IDW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      fall_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      fall_q  <= fall_d;
    end
  end

  assign event_valid = valid_q;
  assign event_id    = id_q;
  assign event_fall  = fall_q;
endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Multi-channel edge-event collector and round-robin scheduler. Each of `N` level inputs gets per-channel rising/falling edge detection. Each detected edge is held as a pending event. Pending events are then serialized one at a time onto a single valid/ready event port. The block sits between synchronized status/interrupt-style level lines and a single consumer (interrupt controller, event FIFO or CPU-visible register block) that can accept only one event per cycle.

## Interface
- `N`, default 4: number of level channels, 2..32.
- `INITIAL_DATA`, default 1'b0: reset value of every channel's level history bit.
- `DETECT_RISE`, default 1'b1: 1 = rising edges generate events.
- `DETECT_FALL`, default 1'b0: 1 = falling edges generate events.
- `IDW`, default `$clog2(N)`: event ID width (derived; do not override).

Ports:
- `clk`, input, 1: single clock; all logic on posedge.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `level`, input, N: level inputs, already synchronous to `clk`.
- `event_valid`, output, 1: an event is presented.
- `event_ready`, input, 1: consumer accepts the event this cycle.
- `event_id`, output, IDW: channel index of the presented event.
- `event_fall`, output, 1: 1 = falling-edge event, 0 = rising-edge event.
- `overflow`, output, N: sticky per-channel lost-event flags.
- `clear_overflow`, input, 1: synchronous clear of all `overflow` bits.

## Operation
- **Edge detection, per channel `i`:**
  - `level_reg[i] <= level[i]` every cycle.
  - `rise[i] = level[i] & ~level_reg[i] & DETECT_RISE`.
  - `fall[i] = ~level[i] & level_reg[i] & DETECT_FALL`.
  - `edge[i] = rise[i] | fall[i]`.
- **Pending state, per channel:** `pend[i]` plus type bit `ptype[i]` (1 = fall).
  - `edge[i]` with `pend[i]` = 0 sets `pend[i]` and loads `ptype[i] <= fall[i]`.
  - `edge[i]` with `pend[i]` = 1, where channel `i` is not being granted this cycle: sets `overflow[i]`. `pend[i]` and `ptype[i]` are unchanged, and the new edge is dropped.
  - `edge[i]` in the same cycle channel `i` is granted: the old event moves to the output slot. `pend[i]` stays 1 with `ptype[i] <= fall[i]`. No overflow.
- **Output slot:** registers `event_valid`, `event_id`, `event_fall`.
  - The slot is free when `event_valid` = 0, or when `event_valid & event_ready` = 1.
  - When the slot is free and any `pend` = 1, grant the winner:
    - load `event_id <= winner` and `event_fall <= ptype[winner]`;
    - set `event_valid <= 1`;
    - clear `pend[winner]`, subject to the same-cycle edge rule above.
  - When the slot is free and no `pend` is set: `event_valid <= 0`.
  - While `event_valid` = 1 and `event_ready` = 0, `event_id` and `event_fall` hold stable.
- **Arbitration:** round-robin.
  - Pointer `ptr`, IDW bits, reset 0.
  - Winner = first `i` with `pend[i]` = 1, searching `ptr`, `ptr+1`, …, `N-1`, 0, …, `ptr-1`.
  - On every grant, `ptr <= (winner+1) mod N`. Wrap from `N-1` to 0 is required for non-power-of-2 `N`.
  - The pointer is unchanged when there is no grant.
- **Overflow clearing:** `clear_overflow` clears all bits. A set in the same cycle wins over the clear.

## Timing
- **Reset values:**
  - `level_reg` = all `INITIAL_DATA`.
  - `pend` = 0, `ptype` = 0, `ptr` = 0.
  - `event_valid` = 0, `event_id` = 0, `event_fall` = 0, `overflow` = 0.
- **Reset mid-operation:** all pending and in-flight events are discarded. Outputs go to reset values immediately (asynchronous).
- **Latency:** `level` changes in cycle 0 → `pend` set in cycle 1 → `event_valid` = 1 in cycle 2 (slot idle).
- **Throughput:** with `event_ready` held 1, one event per cycle with no bubbles between back-to-back events.
- **Fairness:** with all channels continuously pending, each channel is granted at least once every N grants.
- **First edge after reset:** a level that differs from `INITIAL_DATA` in the first cycle after reset produces an edge. This is intended.
- **Combinational paths:** none from `event_ready` to `event_valid`, `event_id` or `event_fall`. Outputs are registered.

## Test plan
- **Single event, N=4, rise only:** raise `level[2]` in cycle 0, `event_ready`=1 → `event_valid`=1 in cycle 2 with `event_id`=2, `event_fall`=0 for one cycle, then `event_valid`=0.
- **Simultaneous edges:** raise `level[3:0]`=4'b1111 in one cycle, `event_ready`=1 → IDs 0,1,2,3 on four consecutive cycles. Then raise `level[1]` and `level[0]` again (after lowering) → order 0 then 1 (`ptr` wrapped to 0).
- **Backpressure and overflow:** hold `event_ready`=0 with an event for channel 0 presented.
  - Pulse `level[1]` high/low twice → `overflow[1]`=1, ID/fall outputs stable.
  - Release ready → exactly one channel-1 event.
  - `clear_overflow` → `overflow`=0.
- **Both-edge mode (DETECT_FALL=1):** toggle `level[0]` up, then down 3 cycles later, `event_ready`=1 → two events on ID 0 with `event_fall`=0 then 1.
- **Grant/edge collision:** new edge on channel 1 in the cycle its pending event is granted → two channel-1 events delivered, `overflow[1]` stays 0.
- **Asynchronous reset mid-stream:** with 3 events pending and `event_valid`=1, pulse `rst_n` low between clock edges → outputs 0 immediately. After release, with `INITIAL_DATA`=0 and levels still high, one rise event per high channel reappears. `ptr` restarts at 0.
